// File: rtl/ysyx_25060170_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, access sizes
// and the access legality check.
package ysyx_25060170_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // 1 when the access has an illegal size, is misaligned for its size, or
  // falls outside [base, base+span).
  function automatic logic access_err(input logic [31:0] addr,
                                      input logic [2:0]  len,
                                      input logic [31:0] base,
                                      input logic [31:0] span);
    logic [31:0] off;
    logic        bad_len;
    logic        misal;
    logic        oor;
    off     = addr - base;
    bad_len = !((len == LEN_B) || (len == LEN_H) || (len == LEN_W));
    misal   = ((len == LEN_H) && addr[0]) ||
              ((len == LEN_W) && (addr[1:0] != 2'b00));
    oor     = (addr < base) || (off >= span);
    return bad_len | misal | oor;
  endfunction

endpackage

// File: rtl/ysyx_25060170_dmem_resp_byte_lane.sv
// Little-endian byte-lane steering: merges store data into a word and extracts
// right-aligned, zero-extended load data from a word.
module ysyx_25060170_byte_lane (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [2:0]  len,
  input  logic [1:0]  lane,
  output logic [31:0] new_word,
  output logic [31:0] rdata
);
  import ysyx_25060170_mem_pkg::*;

  logic [31:0] mask;
  logic [31:0] wmask;
  logic [4:0]  sh;

  always_comb begin
    mask = 32'h0000_0000;
    sh   = {lane, 3'b000};
    case (len)
      LEN_B:   mask = 32'h0000_00FF;
      LEN_H:   mask = 32'h0000_FFFF;
      LEN_W:   mask = 32'hFFFF_FFFF;
      default: mask = 32'h0000_0000;
    endcase
    wmask    = mask << sh;
    new_word = (old_word & ~wmask) | ((wdata << sh) & wmask);
    rdata    = (old_word >> sh) & mask;
  end

endmodule

// File: rtl/ysyx_25060170_dmem_resp.sv
// Clocked data-memory endpoint for the load/store path: one outstanding
// request, response after LATENCY cycles, errors for bad size/alignment/range.
module ysyx_25060170_dmem_resp #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  import ysyx_25060170_mem_pkg::*;

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        do_access;
  logic        acc_wen;
  logic [31:0] acc_addr;
  logic [2:0]  acc_len;
  logic [31:0] acc_wdata;
  logic [31:0] acc_off;
  logic [IDX_W-1:0] acc_idx;
  logic        acc_err;
  logic        mem_we;
  logic [31:0] old_word;
  logic [31:0] new_word;
  logic [31:0] lane_rdata;

  logic [31:0] mem_q [DEPTH];

  // The access normally uses the captured request; with LATENCY==1 it happens
  // on the accept edge itself, so the live request inputs are used instead.
  always_comb begin
    do_access = 1'b0;
    acc_wen   = wen_q;
    acc_addr  = addr_q;
    acc_len   = len_q;
    acc_wdata = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && (LATENCY == 1)) begin
          do_access = 1'b1;
          acc_wen   = req_wen;
          acc_addr  = req_addr;
          acc_len   = req_len;
          acc_wdata = req_wdata;
        end
      end
      ST_WAIT: do_access = (cnt_q <= 4'd1);
      default: do_access = 1'b0;
    endcase
  end

  assign acc_off  = acc_addr - BASE_ADDR;
  assign acc_idx  = IDX_W'(acc_off >> 2);
  assign acc_err  = access_err(acc_addr, acc_len, BASE_ADDR, SPAN);
  assign old_word = mem_q[acc_idx];
  assign mem_we   = do_access && acc_wen && !acc_err && rst;

  ysyx_25060170_byte_lane u_lane (
    .old_word (old_word),
    .wdata    (acc_wdata),
    .len      (acc_len),
    .lane     (acc_off[1:0]),
    .new_word (new_word),
    .rdata    (lane_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          len_d   = req_len;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_access) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || acc_wen) ? 32'h0 : lane_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      wen_q       <= 1'b0;
      addr_q      <= 32'h0;
      len_q       <= 3'd0;
      wdata_q     <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[acc_idx] <= new_word;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/ysyx_25060170_dmem_resp.md
Name: ysyx_25060170_dmem_resp

Overview:
Data-memory responder: the slave end of the load/store path that the write-back stage drives with address, length and store data. It replaces the combinational DPI-C paddr_read/paddr_write pair with a clocked valid/ready request/response memory. Internal storage is a word array. Responses return after a programmable latency, and misaligned or out-of-range accesses are flagged. It sits between the core's WBU/LSU and nothing else; it is the memory endpoint.

Parameters:
DEPTH, 1024, number of 32-bit words stored (power of two)
BASE_ADDR, 32'h8000_0000, byte address of word 0
LATENCY, 2, cycles from request accept to rsp_valid (legal 1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept request
req_wen  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_len  in  3  access size in bytes: 1, 2 or 4
req_wdata  in  32  store data, right-aligned (low bytes used)
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  32  load data, right-aligned, zero-extended; 0 for stores and errors
rsp_err  out  1  access was misaligned, out of range or had an illegal len

Behaviour:
- Reset (rst low, asynchronous): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Memory contents are not reset.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, capture wen/addr/len/wdata, load the counter with LATENCY-1, and go to WAIT. If LATENCY==1, go directly to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle. When it reaches 0, perform the access and go to RESP.
  - RESP: rsp_valid=1, with rsp_rdata/rsp_err held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE.
  - There is no back-to-back accept in the handshake cycle; one outstanding request at a time.
- Latency: rsp_valid rises exactly LATENCY cycles after the accept edge (req_valid&&req_ready).
- Address decode:
  - offset = req_addr - BASE_ADDR; word index = offset[log2(DEPTH)+1:2]; byte lane = offset[1:0].
  - In range iff BASE_ADDR <= addr and offset < DEPTH*4.
- Error conditions (any one sets rsp_err=1):
  - len not in {1,2,4};
  - len==2 and addr[0]!=0;
  - len==4 and addr[1:0]!=0;
  - out of range.
  - On error there is no memory write, and rsp_rdata=0.
- Store, little-endian:
  - len=1 writes byte lane = wdata[7:0].
  - len=2 writes lanes {lane+1,lane} = wdata[15:0].
  - len=4 writes the whole word.
  - Other bytes of the word are unchanged.
- Load: the selected bytes are shifted down to bit 0 and zero-extended. Sign extension is the requester's job.
- Store response: rsp_valid with rsp_rdata=0, rsp_err per checks. The requester must still handshake it.
- Request inputs are sampled only at accept. Changes to them while in WAIT/RESP are ignored.
- rsp_ready held high in IDLE/WAIT has no effect.
- Reset asserted mid-operation: the pending access is abandoned. If reset lands before the WAIT-exit edge, no write occurs. Outputs return to reset values immediately.
- Memory read and write both happen on the WAIT-exit edge, so a load issued after a store sees the stored data.

Decomposition:
- Shared package ysyx_25060170_mem_pkg holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - len constants LEN_B=3'd1, LEN_H=3'd2, LEN_W=3'd4;
  - a function computing the error flag from addr/len.
- One sub-module is natural: ysyx_25060170_byte_lane. It is combinational and handles write-merge (old word, wdata, len, lane -> new word) and read-extract (word, len, lane -> right-aligned data).

Test Plan:
- Word store/load: store 32'hDEADBEEF to 32'h8000_0010, len 4, then load the same address with LATENCY=2 -> rsp_valid exactly 2 cycles after each accept, rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Byte/half merge: word at 0x8000_0020 = 32'h11223344. Store byte 8'hAA at 0x8000_0021, then half 16'hBEEF at 0x8000_0022, then load the word -> 32'hBEEFAA44. Load half 0x8000_0022 -> 32'h0000BEEF.
- Misaligned: store word at 0x8000_0002, and load half at 0x8000_0001 -> rsp_err=1, rsp_rdata=0. A later load of 0x8000_0000 shows the word unchanged.
- Out of range / illegal len: load at 0x7FFF_FFFC, load at BASE+DEPTH*4, and a request with len=3 -> all rsp_err=1, and req_ready stays 0 until each response handshake.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rdata stable and req_ready=0 throughout. rsp_ready=1 -> next cycle IDLE, req_ready=1.
- Reset mid-op: accept a store of 32'h12345678 at 0x8000_0040, then pulse rst low during WAIT -> outputs return to reset values at once, and a subsequent load of 0x8000_0040 returns the prior contents.
